p2s_4bit_tx: RTL
================

# p2s_4bit_tx

Parallel-to-serial transmitter that converts 4-bit words into a one-bit-per-clock serial stream. It is the upstream partner of the 4-bit serial-to-parallel receiver: its `SO` drives the receiver's `D` on the same `CLK`. A one-word holding register lets a producer queue the next word while the current one shifts out, so back-to-back words are sent with no idle cycle between them.

## Interface
- `WIDTH`, default 4: word width and bits per frame.
- `MSB_FIRST`, default 1: when 1, bit `WIDTH-1` is sent first; when 0, bit 0 is sent first.
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `CLR` in 1: reset, asynchronous and active-high.
- `DIN` in WIDTH: parallel word, sampled when `LD` is accepted.
- `LD` in 1: load strobe; accepted on a rising edge where `RDY`=1.
- `RDY` out 1: holding register empty, so a new word can be accepted.
- `SO` out 1: serial data; forced to 0 whenever `SV`=0.
- `SV` out 1: `SO` carries a valid bit this cycle.
- `FS` out 1: high during the first bit of each word.
- `DONE` out 1: one-cycle pulse during the last bit of each word.
- `ERR` out 1: sticky flag, set by `LD` while `RDY`=0; cleared only by `CLR`.

## Operation
- State `IDLE`:
  - Shift register is empty; `SV`=0.
  - `LD` loads `DIN` straight into the shift register, loads bit count 0 and moves to `SHIFT`.
- State `SHIFT`:
  - One bit is presented per cycle; the bit counter runs from 0 to WIDTH-1.
  - `FS`=1 when count=0; `DONE`=1 when count=WIDTH-1.
- `LD` accepted in `SHIFT` while count is below WIDTH-1: the word goes into the holding register, which sets `hold_full` and drops `RDY`.
- Edge at count=WIDTH-1, with priority in this order:
  1. Holding register full: move it into the shift register, count to 0, stay in `SHIFT`, and clear `hold_full`.
  2. Otherwise, `LD`=1: load `DIN` directly into the shift register, count to 0, stay in `SHIFT`.
  3. Otherwise: go to `IDLE`.
- `RDY` = not `hold_full`. It is a registered value and never depends combinationally on `LD`.
- `LD` while `RDY`=0: the word is dropped, `ERR` is set, and the stream is undisturbed.
- Counter width is clog2(WIDTH). The counter wraps only through the reload rules above and never free-runs.
- Reset values: `SO`=0, `SV`=0, `FS`=0, `DONE`=0, `ERR`=0, `RDY`=1; state `IDLE`; shift and hold registers cleared.
- `CLR` asserted mid-word: outputs take their reset values immediately (asynchronously); any partial word and any held word are lost.

## Timing
- Load latency: `LD` accepted at edge k in `IDLE` puts the first bit on `SO`, with `SV`=1 and `FS`=1, after edge k.
- Each bit is held for exactly one cycle. The last bit is on `SO` after edge k+WIDTH-1, with `DONE`=1.
- Back-to-back: if a second word is queued before the last bit, its first bit follows with no gap. A continuous stream has a period of WIDTH cycles per word.
- `RDY` returns to 1 on the edge that moves the held word into the shift register.
- Downstream: the receiver samples `SO` on the following rising edge. Its data-ready strobe therefore appears WIDTH cycles after `FS`, aligned only if both blocks leave reset together.
- Outputs are registered: `SO`, `SV`, `FS` and `DONE` come directly from flops, with no combinational path from `DIN` or `LD`.

## Structure
- Shared package/header `p2s_pkg` holds:
  - state encoding constants: `IDLE`=0, `SHIFT`=1;
  - default WIDTH;
  - the counter-width function.
- One natural sub-module, `p2s_shreg`: a WIDTH-bit loadable shift register with a direction parameter. The top level keeps the FSM, counter, holding register and `ERR`.

## Test plan
- Reset: assert `CLR` mid-frame -> all outputs reach reset values (`RDY`=1, the rest 0) without a clock edge.
- Single word: `DIN`=4'b0101, one `LD` pulse in `IDLE` -> `SO` sequence 0,1,0,1 on cycles 1-4; `FS` on cycle 1, `DONE` on cycle 4, then `SV`=0.
- Streaming: words 0101, 0110, 1001, 0110, each loaded as soon as `RDY`=1 -> 16 contiguous valid bits 0101 0110 1001 0110; `SV` never drops; the downstream receiver reports Q=5, 6, 9, 6.
- Overrun: two `LD` pulses while the hold register is full -> second word dropped, `ERR`=1 and stays 1 until `CLR`; the transmitted stream is unchanged.
- Direct reload: `LD` exactly on the `DONE` cycle with the hold register empty -> next word's `FS` immediately follows `DONE`, with no gap.
- `MSB_FIRST`=0 with `DIN`=4'b0001 -> `SO` sequence 1,0,0,0.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial transmitter: state encoding,
// default word width and the bit-counter width helper.
package p2s_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int P2S_WIDTH = 4;

    // A one-bit word still needs a one-bit counter so the vector is legal.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/p2s_shreg.sv
// Loadable WIDTH-bit shift register; sout is the bit currently on the line.
// Zeros shift in, so the register drains to all-zero after the last bit.
module p2s_shreg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= MSB_FIRST ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
        end
    end

    assign sout = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/p2s_4bit_tx.sv
// Parallel-to-serial transmitter with a one-word holding register so words
// stream back-to-back; all serial outputs come straight from flops.
module p2s_4bit_tx
    import p2s_pkg::*;
#(
    parameter int WIDTH     = P2S_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LD,
    output logic             RDY,
    output logic             SO,
    output logic             SV,
    output logic             FS,
    output logic             DONE,
    output logic             ERR
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold_dat;
    logic             hold_full;
    logic             fs_q;
    logic             done_q;
    logic             err_q;

    logic             last_bit;
    logic             sh_load;
    logic             sh_shift;
    logic [WIDTH-1:0] sh_din;

    assign last_bit = (state == SHIFT) && (cnt == LAST);

    // Held word wins over a fresh LD at the word boundary.
    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = DIN;
        if (state == IDLE) begin
            sh_load = LD;
        end else begin
            sh_shift = 1'b1;
            if (last_bit && hold_full) begin
                sh_load = 1'b1;
                sh_din  = hold_dat;
            end else if (last_bit && LD) begin
                sh_load = 1'b1;
            end
        end
    end

    p2s_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (CLK),
        .rst   (CLR),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .sout  (SO)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_dat  <= '0;
            hold_full <= 1'b0;
            fs_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            fs_q   <= 1'b0;
            done_q <= 1'b0;
            // A load while the holding register is occupied is dropped.
            if (LD && hold_full) begin
                err_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (LD) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        fs_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (hold_full) begin
                            fs_q      <= 1'b1;
                            hold_full <= 1'b0;
                        end else if (LD) begin
                            fs_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt    <= cnt + 1'b1;
                        done_q <= (cnt == LAST - 1'b1);
                        if (LD && !hold_full) begin
                            hold_dat  <= DIN;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SV   = (state == SHIFT);
    assign FS   = fs_q;
    assign DONE = done_q;
    assign ERR  = err_q;
    assign RDY  = !hold_full;

endmodule
